// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Function : Load/store front end for a 2^ADDR_W-byte big-endian data memory.
//             Byte/half/word loads with zero or sign extension; byte/half
//             stores are read-modify-write because the memory writes only
//             full 32-bit words.
//  Option   : MEM_ACCESS_ALIGN_CHECK_EN - when defined, misaligned half/word
//             requests are errored; otherwise the low address bits are
//             forced to alignment and the access proceeds.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int unsigned ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_RMW_RD = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_RSVD  = 2'b11;

  logic [2:0]        state_q,  state_d;
  logic              write_q,  write_d;
  logic [1:0]        size_q,   size_d;
  logic              signed_q, signed_d;
  logic [1:0]        off_q,    off_d;
  logic [ADDR_W-3:0] widx_q,   widx_d;
  logic [31:0]       wdata_q,  wdata_d;
  logic [31:0]       merged_q, merged_d;
  logic [31:0]       rdata_q,  rdata_d;
  logic              err_q,    err_d;

  logic              accept;
  logic              err_range;
  logic              err_size;
  logic              err_align;
  logic [1:0]        acc_off;
  logic [7:0]        lane8;
  logic [15:0]       lane16;
  logic [31:0]       ext_data;
  logic [31:0]       merge_data;

  assign accept    = req_valid && (state_q == S_IDLE);
  assign err_range = (req_addr[31:ADDR_W] != BASE_ADDR[31:ADDR_W]);
  assign err_size  = (req_size == SZ_RSVD);

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign err_align = ((req_size == SZ_HALF) && req_addr[0]) ||
                     ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign acc_off   = req_addr[1:0];
`else
  // Without alignment checking, misaligned low bits are simply dropped.
  assign err_align = 1'b0;
  assign acc_off   = (req_size == SZ_WORD) ? 2'b00 :
                     (req_size == SZ_HALF) ? {req_addr[1], 1'b0} :
                                             req_addr[1:0];
`endif

  // Big-endian lane extraction, load extension and store-lane merge
  always_comb begin
    case (off_q)
      2'd0:    lane8 = mem_rdata[31:24];
      2'd1:    lane8 = mem_rdata[23:16];
      2'd2:    lane8 = mem_rdata[15:8];
      default: lane8 = mem_rdata[7:0];
    endcase
    lane16 = off_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];

    case (size_q)
      SZ_BYTE: ext_data = {{24{signed_q & lane8[7]}}, lane8};
      SZ_HALF: ext_data = {{16{signed_q & lane16[15]}}, lane16};
      default: ext_data = mem_rdata;
    endcase

    merge_data = mem_rdata;
    if (size_q == SZ_HALF) begin
      if (off_q[1]) merge_data[15:0]  = wdata_q[15:0];
      else          merge_data[31:16] = wdata_q[15:0];
    end else begin
      case (off_q)
        2'd0:    merge_data[31:24] = wdata_q[7:0];
        2'd1:    merge_data[23:16] = wdata_q[7:0];
        2'd2:    merge_data[15:8]  = wdata_q[7:0];
        default: merge_data[7:0]   = wdata_q[7:0];
      endcase
    end
  end

  // Next-state and capture logic for the request sequencer
  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    size_d   = size_q;
    signed_d = signed_q;
    off_d    = off_q;
    widx_d   = widx_q;
    wdata_d  = wdata_q;
    merged_d = merged_q;
    rdata_d  = rdata_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          write_d  = req_write;
          size_d   = req_size;
          signed_d = req_signed;
          off_d    = acc_off;
          widx_d   = req_addr[ADDR_W-1:2];
          wdata_d  = req_wdata;
          rdata_d  = 32'h0;
          err_d    = err_range || err_size || err_align;
          if (err_range || err_size || err_align) state_d = S_RESP;
          else if (!req_write)                    state_d = S_READ;
          else if (req_size == SZ_WORD)           state_d = S_WRITE;
          else                                    state_d = S_RMW_RD;
        end
      end
      S_READ: begin
        rdata_d = ext_data;
        state_d = S_RESP;
      end
      S_RMW_RD: begin
        merged_d = merge_data;
        state_d  = S_WRITE;
      end
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; async reset kills any in-flight write immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      off_q    <= 2'b00;
      widx_q   <= '0;
      wdata_q  <= 32'h0;
      merged_q <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      off_q    <= off_d;
      widx_q   <= widx_d;
      wdata_q  <= wdata_d;
      merged_q <= merged_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Outputs decoded from state so they are clean from reset
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_RESP);
    resp_err   = (state_q == S_RESP) && err_q;
    resp_rdata = (state_q == S_RESP) ? rdata_q : 32'h0;
    mem_we     = (state_q == S_WRITE) && write_q;
    mem_addr   = (state_q == S_IDLE) ? '0 : {widx_q, 2'b00};
    mem_wdata  = (state_q != S_WRITE) ? 32'h0 :
                 (size_q == SZ_WORD)  ? wdata_q : merged_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_unit
//  Function : Directed self-checking bench for mem_access_unit with a
//             256-byte big-endian memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  mem_access_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: big-endian bytes, combinational read, 0 while writing
  logic [7:0]  mem [0:255];
  logic        bd_we;
  logic [7:0]  bd_addr;
  logic [31:0] bd_data;
  int          we_total;

  assign mem_rdata = mem_we ? 32'h0 :
    {mem[{mem_addr[7:2], 2'd0}], mem[{mem_addr[7:2], 2'd1}],
     mem[{mem_addr[7:2], 2'd2}], mem[{mem_addr[7:2], 2'd3}]};

  always @(posedge clk) begin
    if (mem_we) begin
      we_total <= we_total + 1;
      mem[{mem_addr[7:2], 2'd0}] <= mem_wdata[31:24];
      mem[{mem_addr[7:2], 2'd1}] <= mem_wdata[23:16];
      mem[{mem_addr[7:2], 2'd2}] <= mem_wdata[15:8];
      mem[{mem_addr[7:2], 2'd3}] <= mem_wdata[7:0];
    end else if (bd_we) begin
      mem[{bd_addr[7:2], 2'd0}] <= bd_data[31:24];
      mem[{bd_addr[7:2], 2'd1}] <= bd_data[23:16];
      mem[{bd_addr[7:2], 2'd2}] <= bd_data[15:8];
      mem[{bd_addr[7:2], 2'd3}] <= bd_data[7:0];
    end
  end

  int n_checks;
  int n_errors;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Observations of the most recent request, cycle 0 = accept cycle
  int          o_resp_cyc, o_we_cnt, o_we_cyc, o_busy_bad;
  logic [31:0] o_we_addr, o_we_data, o_rdata;
  logic        o_err, o_ready0;

  task automatic run_req(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
    o_resp_cyc = -1; o_we_cnt = 0; o_we_cyc = -1; o_busy_bad = 0;
    o_we_addr = 32'h0; o_we_data = 32'h0; o_rdata = 32'h0; o_err = 1'b0;
    @(negedge clk);
    req_write = wr; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    o_ready0 = req_ready;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (mem_we) begin
        o_we_cnt++; o_we_cyc = c;
        o_we_addr = {24'h0, mem_addr}; o_we_data = mem_wdata;
      end
      if (req_ready) o_busy_bad++;
      if (resp_valid) begin
        o_resp_cyc = c; o_rdata = resp_rdata; o_err = resp_err;
        break;
      end
    end
  endtask

  task automatic chk_load(input string tag, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] exp);
    run_req(1'b0, sz, sg, a, 32'h0);
    check_eq({tag, ".ready0"}, 32'(o_ready0), 32'd1);
    check_eq({tag, ".cyc"},    32'(o_resp_cyc), 32'd2);
    check_eq({tag, ".rdata"},  o_rdata, exp);
    check_eq({tag, ".err"},    32'(o_err), 32'd0);
    check_eq({tag, ".we"},     32'(o_we_cnt), 32'd0);
    check_eq({tag, ".busy"},   32'(o_busy_bad), 32'd0);
  endtask

  task automatic chk_error(input string tag, input logic [1:0] sz, input logic [31:0] a);
    run_req(1'b0, sz, 1'b0, a, 32'h0);
    check_eq({tag, ".cyc"},   32'(o_resp_cyc), 32'd1);
    check_eq({tag, ".err"},   32'(o_err), 32'd1);
    check_eq({tag, ".rdata"}, o_rdata, 32'h0);
    check_eq({tag, ".we"},    32'(o_we_cnt), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    check_eq({tag, ".ready"},  32'(req_ready), 32'd1);
    check_eq({tag, ".rvalid"}, 32'(resp_valid), 32'd0);
    check_eq({tag, ".rerr"},   32'(resp_err), 32'd0);
    check_eq({tag, ".rdata"},  resp_rdata, 32'h0);
    check_eq({tag, ".we"},     32'(mem_we), 32'd0);
    check_eq({tag, ".maddr"},  32'(mem_addr), 32'd0);
    check_eq({tag, ".mwdata"}, mem_wdata, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  int we_snap;

  initial begin
    n_checks = 0; n_errors = 0; we_total = 0;
    bd_we = 1'b0; bd_addr = 8'h0; bd_data = 32'h0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    rst_n = 1'b0;

    poke(8'h10, 32'h1122_3344);
    poke(8'h20, 32'h80FF_7F01);
    poke(8'h40, 32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk_reset_outputs("reset");

    // Loads with lane selection and extension
    chk_load("ld_b12u",  2'b00, 1'b0, 32'h12, 32'h0000_0033);
    chk_load("ld_b20s",  2'b00, 1'b1, 32'h20, 32'hFFFF_FF80);
    chk_load("ld_b23u",  2'b00, 1'b0, 32'h23, 32'h0000_0001);
    chk_load("ld_h22s",  2'b01, 1'b1, 32'h22, 32'h0000_7F01);
    chk_load("ld_h20u",  2'b01, 1'b0, 32'h20, 32'h0000_80FF);
    chk_load("ld_h20s",  2'b01, 1'b1, 32'h20, 32'hFFFF_80FF);
    chk_load("ld_w20s",  2'b10, 1'b1, 32'h20, 32'h80FF_7F01);

    // Byte store via read-modify-write
    run_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AB);
    check_eq("st_b11.wecnt", 32'(o_we_cnt), 32'd1);
    check_eq("st_b11.wecyc", 32'(o_we_cyc), 32'd2);
    check_eq("st_b11.addr",  o_we_addr, 32'h10);
    check_eq("st_b11.data",  o_we_data, 32'h11AB_3344);
    check_eq("st_b11.cyc",   32'(o_resp_cyc), 32'd3);
    check_eq("st_b11.rdata", o_rdata, 32'h0);
    check_eq("st_b11.busy",  32'(o_busy_bad), 32'd0);
    chk_load("ld_w10", 2'b10, 1'b0, 32'h10, 32'h11AB_3344);

    // Word store: direct single write
    run_req(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEAD_BEEF);
    check_eq("st_w40.wecnt", 32'(o_we_cnt), 32'd1);
    check_eq("st_w40.wecyc", 32'(o_we_cyc), 32'd1);
    check_eq("st_w40.addr",  o_we_addr, 32'h40);
    check_eq("st_w40.data",  o_we_data, 32'hDEAD_BEEF);
    check_eq("st_w40.cyc",   32'(o_resp_cyc), 32'd2);
    check_eq("st_w40.rdata", o_rdata, 32'h0);
    check_eq("st_w40.err",   32'(o_err), 32'd0);

    // Half store into the low half of the word just written
    run_req(1'b1, 2'b01, 1'b0, 32'h42, 32'h0000_1234);
    check_eq("st_h42.wecyc", 32'(o_we_cyc), 32'd2);
    check_eq("st_h42.data",  o_we_data, 32'hDEAD_1234);
    check_eq("st_h42.cyc",   32'(o_resp_cyc), 32'd3);
    chk_load("ld_w40", 2'b10, 1'b0, 32'h40, 32'hDEAD_1234);

    // Error responses
    chk_error("err_size",  2'b11, 32'h10);
    chk_error("err_range", 2'b10, 32'h100);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    chk_error("err_align", 2'b10, 32'h102);
    chk_error("err_alignh", 2'b01, 32'h41);
`else
    chk_load("ld_w42_forced", 2'b10, 1'b0, 32'h42, 32'hDEAD_1234);
    chk_load("ld_h43_forced", 2'b01, 1'b0, 32'h43, 32'h0000_1234);
`endif

    // Reset asserted during the read phase of a byte store
    we_snap = we_total;
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h0000_0055; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check_eq("rst_mid.rmw_we",    32'(mem_we), 32'd0);
    check_eq("rst_mid.rmw_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    #1 chk_reset_outputs("rst_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check_eq("rst_mid.release_ready", 32'(req_ready), 32'd1);
    check_eq("rst_mid.no_write", 32'(we_total - we_snap), 32'd0);
    chk_load("ld_w20_after_rst", 2'b10, 1'b0, 32'h20, 32'h80FF_7F01);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
